// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared types and constants for the immediate generator.
//   - RV32I/RV64I opcode constants for every opcode that carries an immediate
//   - fmt_t: 3-bit format code reported alongside the immediate
//   - imm_bundle_t: decoded result. Fields are sized to the widest build (64),
//     and each instance uses only its low XLEN / PC_W bits.
package imm_gen_pkg;

   localparam int MAX_W = 64;

   localparam logic [6:0] OPC_LUI     = 7'h37;
   localparam logic [6:0] OPC_AUIPC   = 7'h17;
   localparam logic [6:0] OPC_JAL     = 7'h6F;
   localparam logic [6:0] OPC_JALR    = 7'h67;
   localparam logic [6:0] OPC_BRANCH  = 7'h63;
   localparam logic [6:0] OPC_LOAD    = 7'h03;
   localparam logic [6:0] OPC_STORE   = 7'h23;
   localparam logic [6:0] OPC_OPIMM   = 7'h13;
   localparam logic [6:0] OPC_OPIMM32 = 7'h1B;
   localparam logic [6:0] OPC_SYSTEM  = 7'h73;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_SH   = 3'd6,
      FMT_CSR  = 3'd7
   } fmt_t;

   typedef struct packed {
      logic [MAX_W-1:0] imm;
      logic [MAX_W-1:0] target;
      fmt_t             fmt;
      logic             illegal;
      logic [MAX_W-1:0] pc;
   } imm_bundle_t;

   // Sign-extend a 32-bit immediate to the bundle width.
   function automatic logic [MAX_W-1:0] sext32(input logic [31:0] v);
      return {{(MAX_W-32){v[31]}}, v};
   endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode_core: combinational immediate decoder.
//   instr_i  : raw 32-bit instruction
//   pc_i     : PC of instr_i
//   bundle_o : imm / pc-relative target / format / illegal / pc
// The target is computed at PC_W bits so the carry out of pc + imm is dropped.
module imm_decode_core
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic [31:0]   instr_i,
   input  logic [PC_W-1:0] pc_i,
   output imm_bundle_t   bundle_o
);

   logic [6:0]       opc;
   logic [2:0]       f3;
   logic [5:0]       shamt;
   logic [31:0]      i_imm, s_imm, b_imm, u_imm, j_imm;
   logic [MAX_W-1:0] imm;
   fmt_t             fmt;
   logic             illegal;
   logic             pc_rel;
   logic [PC_W-1:0]  tgt;

   assign opc   = instr_i[6:0];
   assign f3    = instr_i[14:12];
   // RV32 shifts only have a 5-bit shamt; bit 25 belongs to funct7 there.
   assign shamt = (XLEN == 64) ? instr_i[25:20] : {1'b0, instr_i[24:20]};

   assign i_imm = {{20{instr_i[31]}}, instr_i[31:20]};
   assign s_imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign b_imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                   instr_i[11:8], 1'b0};
   assign u_imm = {instr_i[31:12], 12'b0};
   assign j_imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                   instr_i[30:21], 1'b0};

   always_comb begin
      imm     = '0;
      fmt     = FMT_NONE;
      illegal = 1'b0;
      pc_rel  = 1'b0;
      unique case (opc)
         OPC_OPIMM: begin
            if (f3[1:0] == 2'b01) begin
               imm = {{(MAX_W-6){1'b0}}, shamt};
               fmt = FMT_SH;
            end else begin
               imm = sext32(i_imm);
               fmt = FMT_I;
            end
         end
         OPC_LOAD, OPC_JALR: begin
            imm = sext32(i_imm);
            fmt = FMT_I;
         end
         OPC_OPIMM32: begin
            if (XLEN == 64) begin
               imm = sext32(i_imm);
               fmt = FMT_I;
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_STORE: begin
            imm = sext32(s_imm);
            fmt = FMT_S;
         end
         OPC_BRANCH: begin
            imm    = sext32(b_imm);
            fmt    = FMT_B;
            pc_rel = 1'b1;
         end
         OPC_LUI: begin
            imm = sext32(u_imm);
            fmt = FMT_U;
         end
         OPC_AUIPC: begin
            imm    = sext32(u_imm);
            fmt    = FMT_U;
            pc_rel = 1'b1;
         end
         OPC_JAL: begin
            imm    = sext32(j_imm);
            fmt    = FMT_J;
            pc_rel = 1'b1;
         end
         OPC_SYSTEM: begin
            // Only the CSR*I forms carry an immediate (uimm in the rs1 field).
            if (f3[2]) begin
               imm = {{(MAX_W-5){1'b0}}, instr_i[19:15]};
               fmt = FMT_CSR;
            end else begin
               illegal = 1'b1;
            end
         end
         default: illegal = 1'b1;
      endcase
   end

   assign tgt = pc_i + imm[PC_W-1:0];

   always_comb begin
      bundle_o         = '0;
      bundle_o.imm     = imm;
      bundle_o.fmt     = fmt;
      bundle_o.illegal = illegal;
      bundle_o.pc      = MAX_W'(pc_i);
      bundle_o.target  = pc_rel ? MAX_W'(tgt) : '0;
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with valid/ready handshake.
//   clk, reset (sync, active low)
//   valid_i/ready_o/instr_i/pc_i : upstream handshake and instruction
//   flush_i                      : drop everything held and offered
//   valid_o/ready_i              : downstream handshake
//   imm_o/target_o/fmt_o/illegal_o/pc_o : decoded bundle held in M
// M drives the outputs, S catches the one instruction that can arrive in the
// cycle downstream stalls. ready_o is just !S.valid, so it is a flop output
// with no path from ready_i.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [31:0]     instr_i,
   input  logic [PC_W-1:0] pc_i,
   input  logic            flush_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] imm_o,
   output logic [PC_W-1:0] target_o,
   output logic [2:0]      fmt_o,
   output logic            illegal_o,
   output logic [PC_W-1:0] pc_o
);

   imm_bundle_t dec;
   imm_bundle_t m_q, m_d, s_q, s_d;
   logic        m_vld_q, m_vld_d, s_vld_q, s_vld_d;
   logic        xfer, drain;
   logic        unused_bits;

   imm_decode_core #(.XLEN(XLEN), .PC_W(PC_W)) u_dec (
      .instr_i (instr_i),
      .pc_i    (pc_i),
      .bundle_o(dec)
   );

   assign ready_o = !s_vld_q;
   assign xfer    = valid_i && ready_o && !flush_i;
   assign drain   = m_vld_q && ready_i;

   always_comb begin
      m_d     = m_q;
      s_d     = s_q;
      m_vld_d = m_vld_q;
      s_vld_d = s_vld_q;
      if (flush_i) begin
         m_vld_d = 1'b0;
         s_vld_d = 1'b0;
      end else if (s_vld_q) begin
         // FULL: no transfer possible, only S -> M on drain.
         if (drain) begin
            m_d     = s_q;
            s_vld_d = 1'b0;
         end
      end else if (m_vld_q) begin
         // ONE
         if (xfer && drain) begin
            m_d = dec;
         end else if (xfer) begin
            s_d     = dec;
            s_vld_d = 1'b1;
         end else if (drain) begin
            m_vld_d = 1'b0;
         end
      end else if (xfer) begin
         // EMPTY
         m_d     = dec;
         m_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         m_q     <= '0;
         s_q     <= '0;
         m_vld_q <= 1'b0;
         s_vld_q <= 1'b0;
      end else begin
         m_q     <= m_d;
         s_q     <= s_d;
         m_vld_q <= m_vld_d;
         s_vld_q <= s_vld_d;
      end
   end

   assign valid_o   = m_vld_q;
   assign imm_o     = m_q.imm[XLEN-1:0];
   assign target_o  = m_q.target[PC_W-1:0];
   assign fmt_o     = m_q.fmt;
   assign illegal_o = m_q.illegal;
   assign pc_o      = m_q.pc[PC_W-1:0];

   // Upper bundle bits beyond XLEN / PC_W are don't-care in narrow builds.
   assign unused_bits = ^{m_q.imm, m_q.target, m_q.pc};

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        reset;
   // 32-bit build
   logic        valid_i, ready_o, flush_i, valid_o, ready_i, illegal_o;
   logic [31:0] instr_i, pc_i, imm_o, target_o, pc_o;
   logic [2:0]  fmt_o;
   // 64-bit build
   logic        v64_valid_i, v64_ready_o, v64_flush_i, v64_valid_o, v64_ready_i, v64_illegal_o;
   logic [31:0] v64_instr_i, v64_pc_i, v64_target_o, v64_pc_o;
   logic [63:0] v64_imm_o;
   logic [2:0]  v64_fmt_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .PC_W(32)) dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
      .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .valid_o(valid_o),
      .ready_i(ready_i), .imm_o(imm_o), .target_o(target_o), .fmt_o(fmt_o),
      .illegal_o(illegal_o), .pc_o(pc_o)
   );

   imm_gen_pipe #(.XLEN(64), .PC_W(32)) dut64 (
      .clk(clk), .reset(reset), .valid_i(v64_valid_i), .ready_o(v64_ready_o),
      .instr_i(v64_instr_i), .pc_i(v64_pc_i), .flush_i(v64_flush_i),
      .valid_o(v64_valid_o), .ready_i(v64_ready_i), .imm_o(v64_imm_o),
      .target_o(v64_target_o), .fmt_o(v64_fmt_o), .illegal_o(v64_illegal_o),
      .pc_o(v64_pc_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs change and outputs are sampled 1 time unit
   // after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
      valid_i = v;
      instr_i = ins;
      pc_i    = pc;
   endtask

   initial begin
      reset = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
      drive(1'b0, 32'h0, 32'h0);
      v64_valid_i = 1'b0; v64_flush_i = 1'b0; v64_ready_i = 1'b1;
      v64_instr_i = 32'h0; v64_pc_i = 32'h0;

      // Reset
      step(); step();
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_ready", 64'(ready_o), 64'd1);
      chk("rst_imm", 64'(imm_o), 64'd0);
      chk("rst_target", 64'(target_o), 64'd0);
      chk("rst_fmt", 64'(fmt_o), 64'd0);
      chk("rst_illegal", 64'(illegal_o), 64'd0);
      chk("rst_pc", 64'(pc_o), 64'd0);
      chk("rst64_valid", 64'(v64_valid_o), 64'd0);
      reset = 1'b1;

      // ADDI x1,x0,-1
      drive(1'b1, 32'hFFF00093, 32'h0); step();
      chk("addi_valid", 64'(valid_o), 64'd1);
      chk("addi_imm", 64'(imm_o), 64'hFFFFFFFF);
      chk("addi_fmt", 64'(fmt_o), 64'd1);

      // Format sweep, ready_i = 1
      drive(1'b1, 32'hFE112E23, 32'h0); step();
      chk("sw_imm", 64'(imm_o), 64'hFFFFFFFC);
      chk("sw_fmt", 64'(fmt_o), 64'd2);
      chk("sw_target", 64'(target_o), 64'd0);

      drive(1'b1, 32'hFE000EE3, 32'h100); step();
      chk("beq_imm", 64'(imm_o), 64'hFFFFFFFC);
      chk("beq_target", 64'(target_o), 64'hFC);
      chk("beq_fmt", 64'(fmt_o), 64'd3);
      chk("beq_pc", 64'(pc_o), 64'h100);

      drive(1'b1, 32'h123450B7, 32'h20); step();
      chk("lui_imm", 64'(imm_o), 64'h12345000);
      chk("lui_fmt", 64'(fmt_o), 64'd4);
      chk("lui_target", 64'(target_o), 64'd0);

      drive(1'b1, 32'h008000EF, 32'h40); step();
      chk("jal_imm", 64'(imm_o), 64'h8);
      chk("jal_target", 64'(target_o), 64'h48);
      chk("jal_fmt", 64'(fmt_o), 64'd5);

      drive(1'b1, 32'h40305093, 32'h0); step();
      chk("srai_imm", 64'(imm_o), 64'd3);
      chk("srai_fmt", 64'(fmt_o), 64'd6);

      // CSRRWI x0, 0x300, 31
      drive(1'b1, 32'h300FD073, 32'h0); step();
      chk("csri_imm", 64'(imm_o), 64'd31);
      chk("csri_fmt", 64'(fmt_o), 64'd7);

      drive(1'b0, 32'h0, 32'h0); step();
      chk("idle_valid", 64'(valid_o), 64'd0);

      // Backpressure: offer imm 1..4, only 1 and 2 fit
      ready_i = 1'b0;
      drive(1'b1, 32'h00100093, 32'h0); step();
      chk("bp_ready1", 64'(ready_o), 64'd1);
      drive(1'b1, 32'h00200093, 32'h0); step();
      chk("bp_ready2", 64'(ready_o), 64'd0);
      drive(1'b1, 32'h00300093, 32'h0); step();
      drive(1'b1, 32'h00400093, 32'h0); step();
      chk("bp_hold_valid", 64'(valid_o), 64'd1);
      chk("bp_hold_imm", 64'(imm_o), 64'd1);
      chk("bp_hold_ready", 64'(ready_o), 64'd0);
      drive(1'b0, 32'h0, 32'h0);
      ready_i = 1'b1; step();
      chk("bp_drain2_valid", 64'(valid_o), 64'd1);
      chk("bp_drain2_imm", 64'(imm_o), 64'd2);
      chk("bp_drain2_ready", 64'(ready_o), 64'd1);
      step();
      chk("bp_empty", 64'(valid_o), 64'd0);

      // Flush while FULL with an input offered
      ready_i = 1'b0;
      drive(1'b1, 32'h00500093, 32'h0); step();
      drive(1'b1, 32'h00600093, 32'h0); step();
      chk("fl_full", 64'(ready_o), 64'd0);
      drive(1'b1, 32'h00700093, 32'h0);
      flush_i = 1'b1; step();
      chk("fl_valid", 64'(valid_o), 64'd0);
      chk("fl_ready", 64'(ready_o), 64'd1);
      flush_i = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      ready_i = 1'b1; step();
      chk("fl_nolate", 64'(valid_o), 64'd0);

      // Flush with ready_o = 1: offered input is dropped
      drive(1'b1, 32'h00800093, 32'h0);
      flush_i = 1'b1; step();
      flush_i = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      chk("fl2_valid", 64'(valid_o), 64'd0);
      step();
      chk("fl2_nolate", 64'(valid_o), 64'd0);

      // Illegal opcode
      drive(1'b1, 32'h0000007F, 32'h0); step();
      chk("ill_illegal", 64'(illegal_o), 64'd1);
      chk("ill_imm", 64'(imm_o), 64'd0);
      chk("ill_fmt", 64'(fmt_o), 64'd0);

      // AUIPC wrap
      drive(1'b1, 32'h00001097, 32'hFFFFF800); step();
      chk("auipc_imm", 64'(imm_o), 64'h1000);
      chk("auipc_target", 64'(target_o), 64'h800);
      chk("auipc_illegal", 64'(illegal_o), 64'd0);

      // ADDIW on XLEN = 32 is illegal
      drive(1'b1, 32'hFFF0009B, 32'h0); step();
      chk("addiw32_illegal", 64'(illegal_o), 64'd1);
      chk("addiw32_imm", 64'(imm_o), 64'd0);
      drive(1'b0, 32'h0, 32'h0);

      // XLEN = 64 build
      v64_valid_i = 1'b1; v64_instr_i = 32'hFFF0009B; step();
      chk("addiw64_valid", 64'(v64_valid_o), 64'd1);
      chk("addiw64_imm", v64_imm_o, 64'hFFFFFFFFFFFFFFFF);
      chk("addiw64_fmt", 64'(v64_fmt_o), 64'd1);
      chk("addiw64_illegal", 64'(v64_illegal_o), 64'd0);
      v64_instr_i = 32'h43F0D093; step();
      chk("srai64_imm", v64_imm_o, 64'd63);
      chk("srai64_fmt", 64'(v64_fmt_o), 64'd6);
      v64_instr_i = 32'hFE000EE3; v64_pc_i = 32'h2; step();
      chk("beq64_imm", v64_imm_o, 64'hFFFFFFFFFFFFFFFC);
      chk("beq64_target", 64'(v64_target_o), 64'hFFFFFFFE);
      v64_valid_i = 1'b0; step();
      chk("idle64_valid", 64'(v64_valid_o), 64'd0);

      // Reset mid-transfer discards held data
      ready_i = 1'b0;
      drive(1'b1, 32'h00900093, 32'h0); step();
      drive(1'b1, 32'h00A00093, 32'h0);
      reset = 1'b0; step();
      reset = 1'b1;
      drive(1'b0, 32'h0, 32'h0);
      chk("mrst_valid", 64'(valid_o), 64'd0);
      chk("mrst_ready", 64'(ready_o), 64'd1);
      chk("mrst_imm", 64'(imm_o), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage of the pipelined RISC-V core.
- Decodes every RV32I/RV64I immediate format and reports which format it used.
- Also computes the PC-relative target (pc + imm) for branches, jumps and AUIPC.
- Sits between the IF/ID register and the hazard/ID-EX logic, with a valid/ready handshake and a 2-entry skid buffer so stalls never drop an instruction.

Parameters:
- XLEN, 32: datapath width; legal values 32 or 64.
- PC_W, 32: PC width; must be ≤ XLEN.

Ports:
- clk  in  1: clock; all state updates on the rising edge.
- reset  in  1: synchronous, active-low reset.
- valid_i  in  1: instr_i and pc_i are valid.
- ready_o  out  1: block can accept an input this cycle.
- instr_i  in  32: raw instruction word.
- pc_i  in  PC_W: PC of instr_i.
- flush_i  in  1: discard all held and incoming instructions.
- valid_o  out  1: output bundle is valid.
- ready_i  in  1: downstream accepts the output bundle.
- imm_o  out  XLEN: decoded immediate.
- target_o  out  PC_W: pc + imm_o, truncated to PC_W bits.
- fmt_o  out  3: format code (see package).
- illegal_o  out  1: opcode has no immediate decode.
- pc_o  out  PC_W: pc of the held instruction.

Behaviour:
- Reset: when reset = 0 at a clock edge, both buffer entries are cleared. Afterwards valid_o = 0, ready_o = 1, and imm_o, target_o, fmt_o, illegal_o and pc_o are all 0. Reset mid-transfer discards everything.
- Latency: exactly 1 cycle from input handshake (valid_i & ready_o) to valid_o when the buffer is empty. Full throughput is 1 instruction per cycle while ready_i = 1.
- Storage: main register M drives the outputs; skid register S holds one overflow entry.
- ready_o = !S.valid. ready_o is a registered value and has no combinational path from ready_i.
- Buffer states and transitions (transfer = input handshake, drain = valid_o & ready_i):
  - EMPTY: transfer → ONE.
  - ONE: transfer & drain → ONE, new data in M. Transfer & !drain → FULL, new data in S. Drain & !transfer → EMPTY.
  - FULL: drain → ONE, S moves to M.
- Data in M and S never change while valid_o = 1 and ready_i = 0.
- Decode is combinational on the input side and is registered into M or S. Bits are numbered from instr[31:0].
  - OP-IMM 0x13, LOAD 0x03, JALR 0x67: I-format, sext(instr[31:20]).
  - OP-IMM shifts (funct3 = 001 or 101): zero-extended shamt. Shamt is instr[24:20] when XLEN = 32, instr[25:20] when XLEN = 64.
  - STORE 0x23: S-format, sext({instr[31:25], instr[11:7]}).
  - BRANCH 0x63: B-format, sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - LUI 0x37 and AUIPC 0x17: U-format, sext({instr[31:12], 12'b0}).
  - JAL 0x6F: J-format, sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - SYSTEM 0x73 with funct3[2] = 1: CSR-format, zero-extended instr[19:15].
  - OP-IMM-32 0x1B: I-format when XLEN = 64. When XLEN = 32 it is illegal.
  - Any other opcode: imm = 0, fmt = FMT_NONE, illegal = 1.
- target:
  - For BRANCH, JAL and AUIPC: pc_i + imm[PC_W-1:0], modulo 2^PC_W. The carry is dropped, so 0xFFFFFFFC + 8 = 0x00000004.
  - For all other opcodes: target = 0.
- flush_i: takes priority over every other event in the same cycle. Next cycle valid_o = 0, S is empty and ready_o = 1. An input offered during the flush cycle is dropped.
- Simultaneous transfer and drain in FULL cannot occur, because ready_o = 0 in FULL.

Decomposition:
- Shared package imm_gen_pkg holds:
  - Opcode constants OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OPIMM32, OPC_SYSTEM.
  - Format enum fmt_t (3 bits): FMT_NONE = 0, FMT_I = 1, FMT_S = 2, FMT_B = 3, FMT_U = 4, FMT_J = 5, FMT_SH = 6, FMT_CSR = 7.
  - Bundle struct imm_bundle_t with fields imm, target, fmt, illegal and pc.
- One combinational sub-module, imm_decode_core, maps instr and pc to imm_bundle_t. The top module instantiates it once and owns the M/S skid control.

Test Plan:
1. Reset check: hold reset = 0 for 2 cycles → valid_o = 0, ready_o = 1, all outputs 0. Release reset, send ADDI x1,x0,-1 (0xFFF00093) → next cycle valid_o = 1, imm_o = 0xFFFFFFFF, fmt_o = FMT_I.
2. Format sweep, one per cycle, with ready_i = 1:
   - SW (0xFE112E23) → imm 0xFFFFFFFC.
   - BEQ (0xFE000EE3), pc = 0x100 → imm 0xFFFFFFFC, target 0xFC.
   - LUI (0x123450B7) → imm 0x12345000.
   - JAL (0x008000EF), pc = 0x40 → target 0x48.
   - SRAI (0x40305093) → imm 3, fmt FMT_SH.
3. Backpressure: stream 4 instructions while ready_i = 0 → 2 accepted, ready_o = 0 after the 2nd. Raise ready_i → outputs drain in order with no loss or duplication.
4. Flush: with FULL and valid_i = 1, pulse flush_i → next cycle valid_o = 0, ready_o = 1, and the input offered that cycle never appears at the output.
5. Illegal and wrap: opcode 0x7F → illegal_o = 1, imm_o = 0. AUIPC with imm 0x00001000 at pc = 0xFFFFF800 → target 0x00000800.
6. XLEN = 64 build: ADDIW (0xFFF0009B) → imm 0xFFFFFFFFFFFFFFFF. SRAI with shamt 63 → imm 63. The same ADDIW word in an XLEN = 32 build → illegal_o = 1.
